// File: rtl/iterative_mod_unit.sv
// iterative_mod_unit
//   Unsigned divider producing quotient and remainder by restoring division,
//   one quotient bit per clock. Operands arrive on a valid/ready handshake and
//   results leave on a valid/ready handshake. A zero divisor, and optionally a
//   dividend smaller than the divisor, complete without iterating.
//
//   Ports
//     clk          clock, all logic on the rising edge
//     rst          synchronous active-high reset
//     in_valid     operand pair valid
//     in_ready     unit can accept operands (high only in IDLE)
//     dividend     unsigned dividend
//     divisor      unsigned divisor
//     out_valid    result valid (high only in DONE)
//     out_ready    consumer accepts result
//     quotient     dividend / divisor  (all ones for a zero divisor)
//     remainder    dividend % divisor  (dividend for a zero divisor)
//     div_by_zero  result was produced with divisor == 0
//     busy         unit is not idle
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for an operand pair, in_ready high
//   CALC  | one restoring-division step per edge, WIDTH steps in total
//   DONE  | result presented, held until out_ready

module iterative_mod_unit #(
    parameter int WIDTH     = 16,
    parameter bit FAST_PATH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] divisor_reg;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // The shifted partial remainder can reach 2*divisor-1, so the trial
    // subtraction is carried one bit wider; diff[WIDTH] is the borrow.
    assign shifted = {r_reg, q_reg[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor_reg};
    assign r_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next  = {q_reg[WIDTH-2:0], ~diff[WIDTH]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            counter     <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            divisor_reg <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        divisor_reg <= divisor;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        if (divisor == '0) begin
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end else if (FAST_PATH && (dividend < divisor)) begin
                            state       <= DONE;
                            quotient    <= '0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                        end else begin
                            state   <= CALC;
                            counter <= '0;
                            r_reg   <= '0;
                            q_reg   <= dividend;
                        end
                    end
                end
                CALC: begin
                    r_reg   <= r_next;
                    q_reg   <= q_next;
                    counter <= counter + CW'(1);
                    if (counter == LAST_STEP) begin
                        state       <= DONE;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                    end
                end
                DONE: begin
                    // in_ready stays low on the retirement edge, so a new
                    // operand pair is taken no earlier than the next edge.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_mod_unit.sv
// tb_iterative_mod_unit
//   Directed and random checks of iterative_mod_unit with WIDTH=16. Instance
//   dut uses FAST_PATH=1, instance dut_nf uses FAST_PATH=0. Latency below is
//   the number of rising edges from the accept edge (counted as 1) up to and
//   including the edge that raises out_valid: 1 for an early result, 17 for
//   an iterating one (accept edge plus 16 CALC edges).

module tb_iterative_mod_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] dividend, divisor, quotient, remainder;
    logic        div_by_zero, busy;

    logic        in_valid_nf, in_ready_nf, out_valid_nf, out_ready_nf;
    logic [15:0] quotient_nf, remainder_nf;
    logic        div_by_zero_nf, busy_nf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    iterative_mod_unit #(.WIDTH(16), .FAST_PATH(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero), .busy(busy)
    );

    iterative_mod_unit #(.WIDTH(16), .FAST_PATH(1'b0)) dut_nf (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_nf), .in_ready(in_ready_nf),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid_nf), .out_ready(out_ready_nf),
        .quotient(quotient_nf), .remainder(remainder_nf),
        .div_by_zero(div_by_zero_nf), .busy(busy_nf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic o_valid(input bit nf);
        return nf ? out_valid_nf : out_valid;
    endfunction
    function automatic logic i_ready(input bit nf);
        return nf ? in_ready_nf : in_ready;
    endfunction
    function automatic logic [15:0] o_q(input bit nf);
        return nf ? quotient_nf : quotient;
    endfunction
    function automatic logic [15:0] o_r(input bit nf);
        return nf ? remainder_nf : remainder;
    endfunction
    function automatic logic o_z(input bit nf);
        return nf ? div_by_zero_nf : div_by_zero;
    endfunction
    function automatic logic o_busy(input bit nf);
        return nf ? busy_nf : busy;
    endfunction

    // One complete operation: optional pre-delay, accept, latency, result,
    // stall_cycles of backpressure with stability checks, then retirement.
    task automatic run_op(input bit nf, input logic [15:0] dvd, input logic [15:0] dsr,
                          input int pre_delay, input int stall_cycles);
        int          cnt;
        int          exp_lat;
        logic [15:0] exp_q, exp_r;
        logic        exp_z;
        logic [31:0] prod;

        if (dsr == 16'd0) begin
            exp_q = 16'hFFFF; exp_r = dvd; exp_z = 1'b1; exp_lat = 1;
        end else begin
            exp_q = dvd / dsr; exp_r = dvd % dsr; exp_z = 1'b0;
            exp_lat = (!nf && dvd < dsr) ? 1 : 17;
        end

        repeat (pre_delay) begin @(posedge clk); #1; end
        cnt = 0;
        while (!i_ready(nf) && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("in_ready_before_accept", {31'd0, i_ready(nf)}, 32'd1);

        dividend = dvd;
        divisor  = dsr;
        if (nf) in_valid_nf = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid    = 1'b0;
        in_valid_nf = 1'b0;
        // operands changing after acceptance must not affect the result
        dividend = 16'($urandom);
        divisor  = 16'($urandom);

        cnt = 1;
        while (!o_valid(nf) && cnt < 40) begin @(posedge clk); #1; cnt++; end
        check("latency", cnt, exp_lat);
        check("quotient", {16'd0, o_q(nf)}, {16'd0, exp_q});
        check("remainder", {16'd0, o_r(nf)}, {16'd0, exp_r});
        check("div_by_zero", {31'd0, o_z(nf)}, {31'd0, exp_z});
        check("busy_in_done", {31'd0, o_busy(nf)}, 32'd1);
        if (dsr != 16'd0) begin
            prod = 32'(o_q(nf)) * 32'(dsr) + 32'(o_r(nf));
            check("invariant_sum", prod, {16'd0, dvd});
            check("invariant_rem_lt", {31'd0, (o_r(nf) < dsr)}, 32'd1);
        end

        for (int i = 0; i < stall_cycles; i++) begin
            @(posedge clk); #1;
            check("stall_out_valid", {31'd0, o_valid(nf)}, 32'd1);
            check("stall_in_ready", {31'd0, i_ready(nf)}, 32'd0);
            check("stall_quotient", {16'd0, o_q(nf)}, {16'd0, exp_q});
            check("stall_remainder", {16'd0, o_r(nf)}, {16'd0, exp_r});
        end

        if (nf) out_ready_nf = 1'b1; else out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready    = 1'b0;
        out_ready_nf = 1'b0;
        check("retire_out_valid", {31'd0, o_valid(nf)}, 32'd0);
        check("retire_in_ready", {31'd0, i_ready(nf)}, 32'd1);
        check("retire_busy", {31'd0, o_busy(nf)}, 32'd0);
        check("retire_hold_quotient", {16'd0, o_q(nf)}, {16'd0, exp_q});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a, b;
        int          mode;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0;
        in_valid_nf = 1'b0; out_ready_nf = 1'b0;
        dividend = '0; divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_quotient", {16'd0, quotient}, 32'd0);
        check("reset_remainder", {16'd0, remainder}, 32'd0);
        check("reset_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;

        // directed vectors: 100/7=14 r2, 5/9=0 r5, 0xBEEF/0, max operands
        run_op(1'b0, 16'd100, 16'd7, 0, 0);
        run_op(1'b0, 16'd5, 16'd9, 0, 0);
        run_op(1'b1, 16'd5, 16'd9, 0, 0);
        run_op(1'b0, 16'hBEEF, 16'd0, 0, 0);
        run_op(1'b1, 16'hBEEF, 16'd0, 0, 0);
        run_op(1'b0, 16'hFFFF, 16'd1, 0, 0);
        run_op(1'b0, 16'hFFFF, 16'hFFFF, 0, 0);
        run_op(1'b1, 16'hFFFF, 16'h0002, 0, 0);
        run_op(1'b0, 16'd0, 16'd5, 0, 0);
        run_op(1'b0, 16'd9, 16'd9, 0, 0);

        // backpressure: result held for 10 cycles before the consumer takes it
        run_op(1'b0, 16'd1000, 16'd33, 0, 10);

        // reset during CALC, at iteration 8
        dividend = 16'h1234; divisor = 16'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("t6_busy_before_reset", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_out_valid", {31'd0, out_valid}, 32'd0);
        check("t6_in_ready", {31'd0, in_ready}, 32'd1);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_quotient", {16'd0, quotient}, 32'd0);
        check("t6_remainder", {16'd0, remainder}, 32'd0);
        check("t6_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("t6_no_late_result", {31'd0, out_valid}, 32'd0);
        run_op(1'b0, 16'h1234, 16'd3, 0, 0);

        // random pairs with handshake stalls
        for (int n = 0; n < 2000; n++) begin
            a    = 16'($urandom);
            mode = $urandom_range(0, 9);
            case (mode)
                0:       b = 16'd0;
                1, 2, 3: b = 16'($urandom_range(1, 15));
                4:       b = (a == 16'hFFFF) ? 16'hFFFF : a + 16'($urandom_range(1, 16'hFFFF - a));
                default: b = 16'($urandom);
            endcase
            run_op(n[0], a, b, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
